// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the MEM-stage load/store unit: access size codes, FSM states
// and the helper that gives the offset bits which must be zero for a given size.
package mem_access_unit_pkg;

    // funct3[1:0] selects the access size; funct3[2] set means zero-extend.
    localparam logic [1:0] SizeByte   = 2'b00;
    localparam logic [1:0] SizeHalf   = 2'b01;
    localparam logic [1:0] SizeWord   = 2'b10;
    localparam logic [1:0] SizeDouble = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StRdWait,
        StWrWait,
        StDone
    } mau_state_e;

    function automatic logic [2:0] size_low_mask(input logic [1:0] size);
        logic [2:0] mask;
        unique case (size)
            SizeByte:   mask = 3'b000;
            SizeHalf:   mask = 3'b001;
            SizeWord:   mask = 3'b011;
            SizeDouble: mask = 3'b111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for an 8-lane bus: store data/mask shift and load extract/extend.
// Purely combinational so it can be shared with a future D-cache.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [2:0]  i_off,
    input  logic [63:0] i_wdata,
    input  logic [63:0] i_rdata,
    output logic [63:0] o_wdata,
    output logic [7:0]  o_wmask,
    output logic [63:0] o_rdata
);

    logic [7:0]  w_base_mask;
    logic [63:0] w_rd_shift;
    logic        w_sext;

    always_comb begin
        w_base_mask = 8'h01;
        unique case (i_funct3[1:0])
            SizeByte:   w_base_mask = 8'h01;
            SizeHalf:   w_base_mask = 8'h03;
            SizeWord:   w_base_mask = 8'h0F;
            SizeDouble: w_base_mask = 8'hFF;
        endcase
    end

    assign o_wmask    = w_base_mask << i_off;
    assign o_wdata    = i_wdata << {i_off, 3'b000};
    assign w_rd_shift = i_rdata >> {i_off, 3'b000};
    assign w_sext     = ~i_funct3[2];

    always_comb begin
        o_rdata = w_rd_shift;
        unique case (i_funct3[1:0])
            SizeByte:   o_rdata = {{56{w_sext & w_rd_shift[7]}}, w_rd_shift[7:0]};
            SizeHalf:   o_rdata = {{48{w_sext & w_rd_shift[15]}}, w_rd_shift[15:0]};
            SizeWord:   o_rdata = {{32{w_sext & w_rd_shift[31]}}, w_rd_shift[31:0]};
            SizeDouble: o_rdata = w_rd_shift;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: one instruction -> one arbiter transaction, with stall request.
// Optional MEM_MISALIGN_CHECK_EN adds misalign_o and refuses misaligned accesses.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid_i,
    input  logic              mem_we_i,
    input  logic [2:0]        mem_funct3_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              mem_flush_i,
    output logic              arb_req_o,
    output logic              arb_we_o,
    output logic [ADDR_W-1:0] arb_addr_o,
    output logic [DATA_W-1:0] arb_wdata_o,
    output logic [7:0]        arb_wmask_o,
    input  logic [DATA_W-1:0] arb_rdata_i,
    input  logic              arb_rdata_ready_i,
    input  logic              arb_wdata_ready_i,
    output logic              ram_stall_valid_mem_o,
    output logic              ls_valid_o,
    output logic [DATA_W-1:0] ls_rdata_o
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic              misalign_o
`endif
);

    mau_state_e        r_state;
    mau_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_funct3;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_killed;

    logic [2:0]        w_low_mask;
    logic [2:0]        w_off_eff;
    logic              w_accept;
    logic              w_in_wait;
    logic [DATA_W-1:0] w_wdata_sh;
    logic [7:0]        w_wmask;
    logic [DATA_W-1:0] w_rdata_ext;

    assign w_low_mask = size_low_mask(mem_funct3_i[1:0]);
    assign w_in_wait  = (r_state == StRdWait) || (r_state == StWrWait);

`ifdef MEM_MISALIGN_CHECK_EN
    logic w_misalign;
    assign w_misalign = |(mem_addr_i[2:0] & w_low_mask);
    assign w_off_eff  = mem_addr_i[2:0];
    assign misalign_o = (r_state == StIdle) && mem_valid_i && w_misalign;
    assign w_accept   = (r_state == StIdle) && mem_valid_i && !mem_flush_i && !w_misalign;
`else
    // Without the check, drop offset bits below the size to force natural alignment.
    assign w_off_eff  = mem_addr_i[2:0] & ~w_low_mask;
    assign w_accept   = (r_state == StIdle) && mem_valid_i && !mem_flush_i;
`endif

    mem_lane_align u_lane (
        .i_funct3 (r_funct3),
        .i_off    (r_addr[2:0]),
        .i_wdata  (r_wdata),
        .i_rdata  (r_rdata),
        .o_wdata  (w_wdata_sh),
        .o_wmask  (w_wmask),
        .o_rdata  (w_rdata_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_addr   <= '0;
            r_funct3 <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_killed <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr   <= {mem_addr_i[ADDR_W-1:3], w_off_eff};
                r_funct3 <= mem_funct3_i;
                r_we     <= mem_we_i;
                r_wdata  <= mem_wdata_i;
            end
            if ((r_state == StRdWait) && arb_rdata_ready_i) begin
                r_rdata <= arb_rdata_i;
            end
            // The bus beat always completes; a flush only suppresses the result.
            if (w_in_wait && mem_flush_i) begin
                r_killed <= 1'b1;
            end else if (r_state == StDone) begin
                r_killed <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt           = r_state;
        arb_req_o             = 1'b0;
        arb_we_o              = 1'b0;
        arb_addr_o            = '0;
        arb_wdata_o           = '0;
        arb_wmask_o           = '0;
        ram_stall_valid_mem_o = w_accept;
        ls_valid_o            = 1'b0;
        ls_rdata_o            = '0;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_nxt = mem_we_i ? StWrWait : StRdWait;
                end
            end
            StRdWait, StWrWait: begin
                if ((r_state == StRdWait) ? arb_rdata_ready_i : arb_wdata_ready_i) begin
                    w_state_nxt = StDone;
                end
                arb_req_o             = 1'b1;
                arb_we_o              = (r_state == StWrWait);
                arb_addr_o            = {r_addr[ADDR_W-1:3], 3'b000};
                arb_wdata_o           = w_wdata_sh;
                arb_wmask_o           = w_wmask;
                ram_stall_valid_mem_o = 1'b1;
            end
            StDone: begin
                w_state_nxt = StIdle;
                ls_valid_o  = !r_killed;
                ls_rdata_o  = (r_killed || r_we) ? '0 : w_rdata_ext;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised self-checking bench for mem_access_unit against a byte-level reference model.
// Honours MEM_MISALIGN_CHECK_EN when the design is built with it.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_valid_i;
    logic        mem_we_i;
    logic [2:0]  mem_funct3_i;
    logic [63:0] mem_addr_i;
    logic [63:0] mem_wdata_i;
    logic        mem_flush_i;
    logic        arb_req_o;
    logic        arb_we_o;
    logic [63:0] arb_addr_o;
    logic [63:0] arb_wdata_o;
    logic [7:0]  arb_wmask_o;
    logic [63:0] arb_rdata_i;
    logic        arb_rdata_ready_i;
    logic        arb_wdata_ready_i;
    logic        ram_stall_valid_mem_o;
    logic        ls_valid_o;
    logic [63:0] ls_rdata_o;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        misalign_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mem_access_unit #(
        .ADDR_W (64),
        .DATA_W (64)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .mem_valid_i           (mem_valid_i),
        .mem_we_i              (mem_we_i),
        .mem_funct3_i          (mem_funct3_i),
        .mem_addr_i            (mem_addr_i),
        .mem_wdata_i           (mem_wdata_i),
        .mem_flush_i           (mem_flush_i),
        .arb_req_o             (arb_req_o),
        .arb_we_o              (arb_we_o),
        .arb_addr_o            (arb_addr_o),
        .arb_wdata_o           (arb_wdata_o),
        .arb_wmask_o           (arb_wmask_o),
        .arb_rdata_i           (arb_rdata_i),
        .arb_rdata_ready_i     (arb_rdata_ready_i),
        .arb_wdata_ready_i     (arb_wdata_ready_i),
        .ram_stall_valid_mem_o (ram_stall_valid_mem_o),
        .ls_valid_o            (ls_valid_o),
        .ls_rdata_o            (ls_rdata_o)
`ifdef MEM_MISALIGN_CHECK_EN
        ,
        .misalign_o            (misalign_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Load result: pick the addressed bytes, then sign- or zero-extend by size.
    function automatic logic [63:0] ref_load(input logic [2:0] f3, input int off,
                                             input logic [63:0] rd);
        int          nb;
        logic [63:0] v;
        logic [63:0] lo;
        nb = 1 << f3[1:0];
        v  = rd >> (8 * off);
        if (nb == 8) return v;
        lo = (64'd1 << (8 * nb)) - 64'd1;
        v  = v & lo;
        if (!f3[2] && v[8*nb-1]) v = v | ~lo;
        return v;
    endfunction

    task automatic run_access(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                              input logic [63:0] wd, input logic [63:0] rd, input int n,
                              input int flush_k, output logic [63:0] got);
        int          nb;
        int          off;
        int          eff;
        int          stalls;
        logic        killed;
        logic [63:0] exp_mask;
        nb       = 1 << f3[1:0];
        off      = int'(addr[2:0]);
        eff      = off - (off % nb);
        killed   = (flush_k >= 0) && (flush_k <= n);
        exp_mask = (((64'd1 << nb) - 64'd1) << eff) & 64'hFF;
        stalls   = 0;
        got      = '0;
        @(posedge clk); #1;
        mem_valid_i  = 1'b1;
        mem_we_i     = we;
        mem_funct3_i = f3;
        mem_addr_i   = addr;
        mem_wdata_i  = wd;
        mem_flush_i  = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        if (off != eff) begin
            @(negedge clk);
            check_eq("misalign", 64'(misalign_o), 64'd1);
            check_eq("misalign_req", 64'(arb_req_o), 64'd0);
            check_eq("misalign_stall", 64'(ram_stall_valid_mem_o), 64'd0);
            @(posedge clk); #1;
            mem_valid_i = 1'b0;
            @(negedge clk);
            check_eq("misalign_after_req", 64'(arb_req_o), 64'd0);
            check_eq("misalign_after_valid", 64'(ls_valid_o), 64'd0);
            return;
        end
`endif
        @(negedge clk);
        check_eq("idle_stall", 64'(ram_stall_valid_mem_o), 64'd1);
        check_eq("idle_req", 64'(arb_req_o), 64'd0);
        if (ram_stall_valid_mem_o) stalls++;
        for (int k = 0; k <= n; k++) begin
            @(posedge clk); #1;
            mem_flush_i       = (k == flush_k);
            arb_rdata_ready_i = !we && (k == n);
            arb_wdata_ready_i = we && (k == n);
            arb_rdata_i       = (k == n) ? rd : {$urandom, $urandom};
            @(negedge clk);
            if (ram_stall_valid_mem_o) stalls++;
            check_eq("wait_req", 64'(arb_req_o), 64'd1);
            check_eq("wait_we", 64'(arb_we_o), 64'(we));
            check_eq("wait_addr", arb_addr_o, addr & ~64'h7);
            check_eq("wait_lsvalid", 64'(ls_valid_o), 64'd0);
            if (we) begin
                check_eq("wait_wmask", 64'(arb_wmask_o), exp_mask);
                check_eq("wait_wdata", arb_wdata_o, wd << (8 * eff));
            end
        end
        @(posedge clk); #1;
        mem_flush_i       = 1'b0;
        arb_rdata_ready_i = 1'b0;
        arb_wdata_ready_i = 1'b0;
        arb_rdata_i       = {$urandom, $urandom};
        @(negedge clk);
        check_eq("done_stall", 64'(ram_stall_valid_mem_o), 64'd0);
        check_eq("done_req", 64'(arb_req_o), 64'd0);
        check_eq("done_lsvalid", 64'(ls_valid_o), 64'(!killed));
        check_eq("stall_cycles", 64'(stalls), 64'(n + 2));
        if (!we) check_eq("done_rdata", ls_rdata_o, killed ? 64'd0 : ref_load(f3, eff, rd));
        got = ls_rdata_o;
        @(posedge clk); #1;
        mem_valid_i = 1'b0;
        @(negedge clk);
        check_eq("post_lsvalid", 64'(ls_valid_o), 64'd0);
        check_eq("post_req", 64'(arb_req_o), 64'd0);
    endtask

    initial begin
        logic [63:0] got;
        logic        we;
        logic [2:0]  f3;
        int          n;
        int          fk;
        rst_n             = 1'b0;
        mem_valid_i       = 1'b0;
        mem_we_i          = 1'b0;
        mem_funct3_i      = 3'b000;
        mem_addr_i        = '0;
        mem_wdata_i       = '0;
        mem_flush_i       = 1'b0;
        arb_rdata_i       = '0;
        arb_rdata_ready_i = 1'b0;
        arb_wdata_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req", 64'(arb_req_o), 64'd0);
        check_eq("rst_stall", 64'(ram_stall_valid_mem_o), 64'd0);
        check_eq("rst_lsvalid", 64'(ls_valid_o), 64'd0);
        check_eq("rst_addr", arb_addr_o, 64'd0);
        rst_n = 1'b1;

        // LW, ready after 3 wait cycles
        run_access(1'b0, 3'b010, 64'h8000_0004, 64'd0, 64'h8765_4321_DEAD_BEEF, 3, -1, got);
        check_eq("lw_result", got, 64'hFFFF_FFFF_8765_4321);
        // SB 0xAB at offset 3
        run_access(1'b1, 3'b000, 64'h1000_0003, 64'h0000_0000_0000_00AB, 64'd0, 1, -1, got);
        // LBU vs LB on byte 0x80 at offset 7
        run_access(1'b0, 3'b100, 64'h2000_0007, 64'd0, 64'h8011_2233_4455_6677, 0, -1, got);
        check_eq("lbu_result", got, 64'h0000_0000_0000_0080);
        run_access(1'b0, 3'b000, 64'h2000_0007, 64'd0, 64'h8011_2233_4455_6677, 2, -1, got);
        check_eq("lb_result", got, 64'hFFFF_FFFF_FFFF_FF80);
        // Flush in RD_WAIT, then a normal access
        run_access(1'b0, 3'b011, 64'h3000_0008, 64'd0, 64'h1234_5678_9ABC_DEF0, 2, 1, got);
        check_eq("flush_result", got, 64'd0);
        run_access(1'b0, 3'b011, 64'h3000_0010, 64'd0, 64'h0FED_CBA9_8765_4321, 1, -1, got);
        check_eq("after_flush", got, 64'h0FED_CBA9_8765_4321);
        // LW at offset 2
        run_access(1'b0, 3'b010, 64'h4000_0002, 64'd0, 64'h1122_3344_5566_7788, 0, -1, got);
`ifndef MEM_MISALIGN_CHECK_EN
        check_eq("lw_off2_aligned", got, 64'h0000_0000_5566_7788);
`endif

        // Flush alongside valid in IDLE: nothing issued
        @(posedge clk); #1;
        mem_valid_i = 1'b1;
        mem_flush_i = 1'b1;
        @(negedge clk);
        check_eq("idle_flush_stall", 64'(ram_stall_valid_mem_o), 64'd0);
        @(posedge clk); #1;
        mem_valid_i = 1'b0;
        mem_flush_i = 1'b0;
        @(negedge clk);
        check_eq("idle_flush_req", 64'(arb_req_o), 64'd0);

        // Asynchronous reset in WR_WAIT
        @(posedge clk); #1;
        mem_valid_i  = 1'b1;
        mem_we_i     = 1'b1;
        mem_funct3_i = 3'b011;
        mem_addr_i   = 64'h5000_0010;
        mem_wdata_i  = 64'hCAFE_F00D_1234_5678;
        @(posedge clk); #1;
        check_eq("wr_wait_req", 64'(arb_req_o), 64'd1);
        #2;
        rst_n       = 1'b0;
        mem_valid_i = 1'b0;
        #1;
        check_eq("async_rst_req", 64'(arb_req_o), 64'd0);
        check_eq("async_rst_stall", 64'(ram_stall_valid_mem_o), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_req", 64'(arb_req_o), 64'd0);
        check_eq("post_rst_lsvalid", 64'(ls_valid_o), 64'd0);

        for (int t = 0; t < 40; t++) begin
            we = 1'($urandom_range(0, 1));
            f3 = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
            n  = int'($urandom_range(0, 4));
            fk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_access(we, f3, {$urandom, $urandom}, {$urandom, $urandom},
                       {$urandom, $urandom}, n, fk, got);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
